// File: rtl/vend_pkg.sv
// Shared definitions for the change-dispenser slice.
//   state_e    : dispenser FSM states
//   sel_e      : which ejector is currently active
//   CNT_W      : width of the per-denomination coin counts
//   DEN1/2/5   : denomination values in K
//   pick_sel   : highest nonzero denomination (5, then 2, then 1)
//   den_value  : value in K for an ejector selection
package vend_pkg;

   localparam int unsigned CNT_W = 2;

   localparam logic [4:0] DEN1 = 5'd1;
   localparam logic [4:0] DEN2 = 5'd2;
   localparam logic [4:0] DEN5 = 5'd5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PULSE,
      S_WAIT,
      S_GAP,
      S_FAULT
   } state_e;

   typedef enum logic [1:0] {
      SEL_NONE,
      SEL_1,
      SEL_2,
      SEL_5
   } sel_e;

   function automatic sel_e pick_sel(input logic [CNT_W-1:0] n5,
                                     input logic [CNT_W-1:0] n2,
                                     input logic [CNT_W-1:0] n1);
      if (n5 != '0)      return SEL_5;
      else if (n2 != '0) return SEL_2;
      else if (n1 != '0) return SEL_1;
      else               return SEL_NONE;
   endfunction

   function automatic logic [4:0] den_value(input sel_e s);
      unique case (s)
         SEL_5:   return DEN5;
         SEL_2:   return DEN2;
         SEL_1:   return DEN1;
         default: return '0;
      endcase
   endfunction

endpackage

// File: rtl/coin_pulse_timer.sv
// Loadable down-counter with a terminal-count flag.
//   clk      : system clock, rising edge
//   Reset    : synchronous active-high reset
//   i_load   : load i_value into the counter this edge
//   i_value  : interval length minus one
//   o_tc     : counter has reached zero
// Loading N-1 makes o_tc assert in the Nth cycle after the load edge.
module coin_pulse_timer
   import vend_pkg::*;
#(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         Reset,
   input  logic         i_load,
   input  logic [W-1:0] i_value,
   output logic         o_tc
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (Reset)
         r_count <= '0;
      else if (i_load)
         r_count <= i_value;
      else if (r_count != '0)
         r_count <= r_count - W'(1);
   end

   assign o_tc = (r_count == '0);

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: ejects the requested coins one at a time, largest
// denomination first, waiting for the drop sensor to confirm each coin.
//   clk        : system clock, rising edge
//   Reset      : synchronous active-high reset
//   load       : start request, counts sampled on the same edge
//   C1/C2/C5   : number of 1K/2K/5K coins to return (0-3)
//   coin_sense : drop sensor, high for >=1 cycle per ejected coin
//   EJ1/EJ2/EJ5: ejector solenoid drives
//   busy       : dispense in progress
//   done       : one-cycle pulse when all coins are confirmed
//   paid       : running value dispensed in K (0-24)
//   fault      : sticky jam indication
module change_dispenser
   import vend_pkg::*;
#(
   parameter int unsigned PULSE_LEN = 2,
   parameter int unsigned GAP_LEN   = 1,
   parameter int unsigned TIMEOUT   = 15
) (
   input  logic             clk,
   input  logic             Reset,
   input  logic             load,
   input  logic [CNT_W-1:0] C1,
   input  logic [CNT_W-1:0] C2,
   input  logic [CNT_W-1:0] C5,
   input  logic             coin_sense,
   output logic             EJ1,
   output logic             EJ2,
   output logic             EJ5,
   output logic             busy,
   output logic             done,
   output logic [4:0]       paid,
   output logic             fault
);

   localparam int unsigned MAX_PT  = (PULSE_LEN > TIMEOUT) ? PULSE_LEN : TIMEOUT;
   localparam int unsigned MAX_LEN = (MAX_PT > GAP_LEN) ? MAX_PT : GAP_LEN;
   localparam int unsigned TW      = $clog2(MAX_LEN) + 1;

   localparam logic [TW-1:0] PULSE_LD = TW'(PULSE_LEN - 1);
   localparam logic [TW-1:0] WAIT_LD  = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] GAP_LD   = (GAP_LEN > 0) ? TW'(GAP_LEN - 1) : '0;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_e           r_state, w_state_next;
   sel_e             r_sel, w_sel_next;
   logic [CNT_W-1:0] r5, r2, r1;
   logic [CNT_W-1:0] w_n5, w_n2, w_n1;
   logic             r_got, r_sense_prev;
   logic             w_hit, w_sensed, w_more;
   logic             w_confirm, w_advance, w_done_evt;
   logic             w_tmr_load, w_tmr_tc;
   logic [TW-1:0]    w_tmr_val;
   logic             w_ej1_next, w_ej2_next, w_ej5_next;
   logic             w_busy_next, w_fault_next, w_done_next;

   coin_pulse_timer #(.W(TW)) u_timer (
      .clk     (clk),
      .Reset   (Reset),
      .i_load  (w_tmr_load),
      .i_value (w_tmr_val),
      .o_tc    (w_tmr_tc)
   );

   // One count per coin: a rising edge inside the PULSE/WAIT window, and
   // only the first such edge since the pulse for this coin started.
   assign w_hit = ((r_state == S_PULSE) || (r_state == S_WAIT)) &&
                  coin_sense && !r_sense_prev && !r_got;
   assign w_sensed = r_got || w_hit;

   // Counts after this edge's decrement; the next-coin decision must see them.
   assign w_n5 = (w_hit && (r_sel == SEL_5)) ? r5 - CNT_ONE : r5;
   assign w_n2 = (w_hit && (r_sel == SEL_2)) ? r2 - CNT_ONE : r2;
   assign w_n1 = (w_hit && (r_sel == SEL_1)) ? r1 - CNT_ONE : r1;
   assign w_more = (w_n5 != '0) || (w_n2 != '0) || (w_n1 != '0);

   // State register
   always_ff @(posedge clk) begin
      if (Reset) begin
         r_state <= S_IDLE;
         r_sel   <= SEL_NONE;
      end else begin
         r_state <= w_state_next;
         r_sel   <= w_sel_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      w_sel_next   = r_sel;
      w_tmr_load   = 1'b0;
      w_tmr_val    = '0;
      w_done_evt   = 1'b0;
      w_confirm    = 1'b0;
      w_advance    = 1'b0;

      unique case (r_state)
         S_IDLE: begin
            if (load) begin
               if ((C5 != '0) || (C2 != '0) || (C1 != '0)) begin
                  w_state_next = S_PULSE;
                  w_sel_next   = pick_sel(C5, C2, C1);
                  w_tmr_load   = 1'b1;
                  w_tmr_val    = PULSE_LD;
               end else begin
                  w_done_evt = 1'b1;
               end
            end
         end
         S_PULSE: begin
            if (w_tmr_tc) begin
               if (w_sensed) begin
                  w_confirm = 1'b1;
               end else begin
                  w_state_next = S_WAIT;
                  w_tmr_load   = 1'b1;
                  w_tmr_val    = WAIT_LD;
               end
            end
         end
         S_WAIT: begin
            if (w_hit)
               w_confirm = 1'b1;
            else if (w_tmr_tc)
               w_state_next = S_FAULT;
         end
         S_GAP: begin
            if (w_tmr_tc)
               w_advance = 1'b1;
         end
         S_FAULT: begin
            w_state_next = S_FAULT;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase

      // A confirmed coin either rests in GAP or, with no gap, advances directly.
      if (w_confirm) begin
         if (GAP_LEN != 0) begin
            w_state_next = S_GAP;
            w_tmr_load   = 1'b1;
            w_tmr_val    = GAP_LD;
         end else begin
            w_advance = 1'b1;
         end
      end

      if (w_advance) begin
         if (w_more) begin
            w_state_next = S_PULSE;
            w_sel_next   = pick_sel(w_n5, w_n2, w_n1);
            w_tmr_load   = 1'b1;
            w_tmr_val    = PULSE_LD;
         end else begin
            w_state_next = S_IDLE;
            w_sel_next   = SEL_NONE;
            w_done_evt   = 1'b1;
         end
      end
   end

   // Output logic (values registered on the next edge)
   always_comb begin
      w_ej5_next   = (w_state_next == S_PULSE) && (w_sel_next == SEL_5);
      w_ej2_next   = (w_state_next == S_PULSE) && (w_sel_next == SEL_2);
      w_ej1_next   = (w_state_next == S_PULSE) && (w_sel_next == SEL_1);
      w_busy_next  = (w_state_next == S_PULSE) || (w_state_next == S_WAIT) ||
                     (w_state_next == S_GAP);
      w_fault_next = (w_state_next == S_FAULT);
      w_done_next  = w_done_evt;
   end

   // Counters, paid accumulator, sense tracking and registered outputs
   always_ff @(posedge clk) begin
      if (Reset) begin
         r5           <= '0;
         r2           <= '0;
         r1           <= '0;
         r_got        <= 1'b0;
         r_sense_prev <= 1'b0;
         paid         <= '0;
         EJ1          <= 1'b0;
         EJ2          <= 1'b0;
         EJ5          <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         fault        <= 1'b0;
      end else begin
         r_sense_prev <= coin_sense;
         EJ1          <= w_ej1_next;
         EJ2          <= w_ej2_next;
         EJ5          <= w_ej5_next;
         busy         <= w_busy_next;
         done         <= w_done_next;
         fault        <= w_fault_next;

         if ((r_state == S_IDLE) && load) begin
            r5   <= C5;
            r2   <= C2;
            r1   <= C1;
            paid <= '0;
         end else begin
            r5 <= w_n5;
            r2 <= w_n2;
            r1 <= w_n1;
            if (w_hit)
               paid <= paid + den_value(r_sel);
         end

         // Every PULSE entry loads the timer, including PULSE->PULSE with no gap.
         if (w_tmr_load && (w_state_next == S_PULSE))
            r_got <= 1'b0;
         else if (w_hit)
            r_got <= 1'b1;
      end
   end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Sits directly downstream of the vending machine controller. Consumes its per-coin change counts (C1/C2/C5, each 0-3) and drives the three coin-ejector solenoids.
- Ejects one coin at a time, largest denomination first, and waits for the drop sensor to confirm each coin.
- Reports busy, completion, running value paid out, and a sticky jam fault.

Parameters:
- PULSE_LEN, 2, cycles an ejector output is held high per coin (>=1).
- GAP_LEN, 1, idle cycles between a confirmed coin and the next pulse (>=0).
- TIMEOUT, 15, cycles allowed after a pulse ends for coin_sense before declaring a jam (>=1).

Ports:
- clk  input  1  system clock, rising edge
- Reset  input  1  synchronous active-high reset
- load  input  1  start request; counts sampled on the same edge
- C1  input  2  number of 1K coins to return
- C2  input  2  number of 2K coins to return
- C5  input  2  number of 5K coins to return
- coin_sense  input  1  drop sensor, high for >=1 cycle per ejected coin
- EJ1  output  1  1K ejector drive
- EJ2  output  1  2K ejector drive
- EJ5  output  1  5K ejector drive
- busy  output  1  high from the load edge until done or fault
- done  output  1  one-cycle pulse when all requested coins are confirmed
- paid  output  5  running value dispensed in K, range 0-24
- fault  output  1  sticky jam indication

Behaviour:
- Reset (synchronous, priority over everything, including mid-dispense):
  - State goes to IDLE; internal counts are cleared.
  - EJ1, EJ2, EJ5, busy, done and fault go to 0; paid goes to 0.
- All outputs are registered.
- States: IDLE, PULSE, WAIT, GAP, FAULT.
- IDLE:
  - load=1 with any count nonzero: latch C5/C2/C1 into down-counters r5/r2/r1, clear paid to 0, set busy=1, and enter PULSE for the highest nonzero denomination. The matching EJx rises on this same edge.
  - load=1 with all counts 0: busy stays 0, paid is cleared to 0, done=1 for one cycle. No ejects.
- PULSE:
  - Exactly one EJx is high for PULSE_LEN cycles.
  - Selection order is 5, then 2, then 1. Never more than one EJ high at once.
  - Then enter WAIT with EJ low.
- Sense window:
  - coin_sense is accepted from the first PULSE cycle through WAIT.
  - A rising edge of coin_sense (0->1 vs previous cycle) counts once. A level held high counts once.
  - A sense seen during PULSE is remembered; the pulse still completes its full length, then the FSM goes directly to GAP.
- On sense:
  - Decrement the active counter.
  - Add the denomination value (1, 2 or 5) to paid, registered, visible next cycle.
- WAIT:
  - If no sense within TIMEOUT cycles, enter FAULT: fault=1, busy=0, all EJ=0, paid frozen.
- GAP:
  - Hold all EJ low for GAP_LEN cycles (GAP_LEN=0 skips GAP).
  - If any counter is still nonzero, go to PULSE for the next denomination.
  - Otherwise, on the next edge: done=1 for one cycle, busy=0, return to IDLE.
- paid holds its final value in IDLE until the next load.
- FAULT: absorbing; load is ignored; only Reset exits.
- load while busy=1: ignored, no effect on counters.
- coin_sense outside the sense window (IDLE, GAP): ignored, no count.
- Widths:
  - paid is 5 bits; max 3*5+3*2+3*1=24, no wrap possible.
  - Timers are sized by $clog2 of the largest parameter + 1.

Decomposition:
- Shared package vend_pkg:
  - State encoding constants.
  - Denomination values DEN1=1, DEN2=2, DEN5=5.
  - Coin-count width (2).
- One sub-module: coin_pulse_timer.
  - Loadable down-counter with a terminal-count flag.
  - Instantiated once and reused for PULSE_LEN, TIMEOUT and GAP_LEN intervals.
- FSM, counters and paid accumulator stay in change_dispenser.

Test Plan:
- Full return: Reset, load with C5=1 C2=1 C1=1, sense 1 cycle after each pulse -> EJ5, then EJ2, then EJ1, each high 2 cycles; paid steps 5, 7, 8; one done pulse; busy low after.
- Zero request: load with all counts 0 -> done=1 on the next edge only; no EJ activity; paid=0; busy never high.
- Max request: C5=3 C2=3 C1=3 with prompt sense -> 9 pulses in order 5,5,5,2,2,2,1,1,1; final paid=24; done once.
- Jam: load C2=2, sense for the first coin only -> after the second pulse plus 15 cycles, fault=1, busy=0, paid=2; a further load is ignored; Reset clears fault and paid.
- Sense edge cases:
  - A coin_sense held high for 4 cycles counts as one coin.
  - A sense arriving during PULSE skips WAIT.
  - A sense in IDLE leaves paid unchanged.
- Reset mid-dispense: Reset asserted while EJ5 is high -> next edge all outputs 0, state IDLE; a subsequent load behaves normally.
